// File: rtl/fetch_pc.sv
// Program counter and fetch stage in front of a combinational program ROM.
// Captures each fetched word into an IR; handles branches with one-slot squash, stall and halt.
module fetch_pc #(
    parameter int unsigned p_size = 6,
    parameter int unsigned i_size = 24
) (
    input  logic              clk,
    input  logic              reset,
    output logic [p_size-1:0] address,
    input  logic [i_size-1:0] instr,
    input  logic              stall,
    input  logic              branch_abs,
    input  logic              branch_rel,
    input  logic [p_size-1:0] branch_target,
    input  logic [p_size-1:0] branch_offset,
    input  logic              halt,
    input  logic              resume,
    output logic [i_size-1:0] ir,
    output logic              ir_valid,
    output logic [p_size-1:0] pc_of_ir,
    output logic              halted
);

    typedef enum logic [0:0] {StRun, StHalted} state_e;

    state_e r_state;
    state_e w_state_next;

    logic [p_size-1:0] r_pc;
    logic [p_size-1:0] r_pc_of_ir;
    logic [i_size-1:0] r_ir;
    logic              r_ir_valid;

    logic [p_size-1:0] w_pc_next;
    logic [p_size-1:0] w_pc_of_ir_next;
    logic [i_size-1:0] w_ir_next;
    logic              w_ir_valid_next;

    // Branches only count when the IR holds a live instruction that could have issued them.
    logic w_take_abs;
    logic w_take_rel;
    assign w_take_abs = branch_abs & r_ir_valid;
    assign w_take_rel = branch_rel & r_ir_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StRun;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StRun:    if (halt) w_state_next = StHalted;
            StHalted: if (resume) w_state_next = StRun;
            default:  w_state_next = StRun;
        endcase
    end

    always_comb begin
        w_pc_next       = r_pc;
        w_pc_of_ir_next = r_pc_of_ir;
        w_ir_next       = r_ir;
        w_ir_valid_next = r_ir_valid;
        unique case (r_state)
            StRun: begin
                if (halt) begin
                    w_ir_valid_next = 1'b0;
                end else if (w_take_abs) begin
                    w_pc_next       = branch_target;
                    w_ir_valid_next = 1'b0;
                end else if (w_take_rel) begin
                    // Wraps modulo the ROM depth; offset is two's complement on p_size bits.
                    w_pc_next       = r_pc_of_ir + branch_offset;
                    w_ir_valid_next = 1'b0;
                end else if (!stall) begin
                    w_ir_next       = instr;
                    w_pc_of_ir_next = r_pc;
                    w_ir_valid_next = 1'b1;
                    w_pc_next       = r_pc + {{(p_size - 1){1'b0}}, 1'b1};
                end
            end
            StHalted: begin
                w_ir_valid_next = 1'b0;
            end
            default: begin
                w_ir_valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc       <= '0;
            r_pc_of_ir <= '0;
            r_ir       <= '0;
            r_ir_valid <= 1'b0;
        end else begin
            r_pc       <= w_pc_next;
            r_pc_of_ir <= w_pc_of_ir_next;
            r_ir       <= w_ir_next;
            r_ir_valid <= w_ir_valid_next;
        end
    end

    assign address  = r_pc;
    assign ir       = r_ir;
    assign ir_valid = r_ir_valid;
    assign pc_of_ir = r_pc_of_ir;
    assign halted   = (r_state == StHalted);

endmodule

// File: doc/fetch_pc.md
Name: fetch_pc

Overview:
- Program counter and fetch stage directly upstream of the program ROM `prog`.
- Drives `prog.address` and captures `prog.instr` into an instruction register (IR) for the decode stage.
- Supports absolute and PC-relative branches with single-slot squash, pipeline stall, and halt/resume.
- Single clock domain; ROM read is combinational, so fetch completes within one cycle.

Parameters:
p_size, 6, program address width; ROM depth is 1<<p_size
i_size, 24, instruction width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
address  output  p_size  ROM address, equal to PC register
instr  input  i_size  ROM data for `address`, combinational
stall  input  1  hold PC and IR contents
branch_abs  input  1  load PC from branch_target
branch_rel  input  1  load PC from pc_of_ir + branch_offset
branch_target  input  p_size  absolute branch destination
branch_offset  input  p_size  two's-complement signed relative offset
halt  input  1  request halt
resume  input  1  leave halted state
ir  output  i_size  registered instruction
ir_valid  output  1  ir holds a live instruction
pc_of_ir  output  p_size  address from which ir was fetched
halted  output  1  core is in HALTED state

Behaviour:
- Reset (async, any time, including mid-branch or halted):
  - pc=0, ir=0, ir_valid=0, pc_of_ir=0, halted=0, state=RUN.
  - First valid IR appears on the first rising edge after reset deasserts.
- `address` is driven combinationally from the PC register only. It must not depend on any input.
- States:
  - RUN: fetching.
  - HALTED: PC frozen, ir_valid=0, halted=1.
- Per-edge priority in RUN, highest first:
  1. halt: state<=HALTED, ir_valid<=0, pc held, ir and pc_of_ir held.
  2. branch_abs: pc<=branch_target, ir_valid<=0 (squash the instruction fetched this cycle).
  3. branch_rel: pc<=pc_of_ir+branch_offset, truncated to p_size bits (modulo 1<<p_size), ir_valid<=0.
  4. stall: pc, ir, ir_valid, pc_of_ir all held.
  5. Otherwise: ir<=instr, pc_of_ir<=pc, ir_valid<=1, pc<=pc+1 mod 1<<p_size.
- Branches override stall. A branch is accepted even while stalled.
- branch_abs and branch_rel asserted together: branch_abs wins.
- Branch inputs are qualified internally with ir_valid. A branch asserted while ir_valid=0 is ignored, and the rule for the next priority level applies.
- Relative offset is sign-extended arithmetic on p_size bits:
  - offset 6'b111111 = -1.
  - pc_of_ir=0, offset=-1 gives pc=63.
- Increment wrap: pc=63 -> 0. Fetching continues; no flag is raised.
- HALTED:
  - resume=1: state<=RUN on that edge; pc unchanged; ir_valid stays 0 for that edge. Normal fetch from the held pc resumes on the following edge.
  - stall, branch and halt inputs are ignored while halted.
  - halt and resume together in HALTED: resume wins.
- halted output is registered and equals (state==HALTED).
- No output has a combinational path from any input except through registers.

Test Plan:
- Reset then free-run 70 cycles with prog.hex loaded:
  - ir/pc_of_ir step through addresses 0..63, then wrap to 0.
  - ir == prog_mem[pc_of_ir] whenever ir_valid=1.
  - ir_valid=0 only during reset.
- Stall held high 3 cycles at pc=5:
  - address stays 5; ir and pc_of_ir (=4) unchanged.
  - On release, next edge gives pc_of_ir=5 and pc=6.
- branch_abs with target=40 while pc_of_ir=10:
  - Next edge: pc=40, ir_valid=0.
  - Following edge: pc_of_ir=40, ir=prog_mem[40].
- branch_rel with offset=6'h3E (-2) at pc_of_ir=1: pc=63 (wrap).
- branch_rel with offset=+3 and branch_abs target=7 asserted together: pc=7.
- Branch with stall=1 in the same cycle: branch taken.
- halt at pc=20:
  - halted=1, ir_valid=0, address held at 20 for 5 cycles despite stall and branch pulses.
  - resume: halted=0 next edge; one edge later pc_of_ir=20, ir_valid=1.
- Async reset asserted mid-cycle while halted, and again mid-branch:
  - All outputs zero immediately, without waiting for a clock edge.
  - Fetch restarts from address 0.
